// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage LC-3b pipeline.
// It produces latch enables and bubble strobes for IF/ID, ID/EX, EX/MEM and MEM/WB,
// plus the PC enable and redirect. It also tracks the two-access LDI/STI sequence,
// holds a branch redirect while a fetch is still outstanding, and counts cycles in
// which the PC did not load.
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 mem_indirect,
    input  logic                 br_taken_mem,
    input  logic [15:0]          br_target,
    input  logic                 ex_is_load,
    input  logic [2:0]           ex_dest,
    input  logic [2:0]           id_src1,
    input  logic [2:0]           id_src2,
    input  logic                 id_use1,
    input  logic                 id_use2,
    output logic                 load_pc,
    output logic                 pc_redirect,
    output logic [15:0]          redirect_target,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 bubble_if_id,
    output logic                 bubble_id_ex,
    output logic                 bubble_ex_mem,
    output logic                 bubble_mem_wb,
    output logic                 mem_phase2,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic {M_IDLE = 1'b0, M_IND2 = 1'b1} mem_state_e;

    mem_state_e           state_q, state_d;
    logic                 redirect_pending_q, redirect_pending_d;
    logic [15:0]          redirect_target_q, redirect_target_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    logic dstall, istall, luse;

    // Hazard detection terms. The first access of an LDI/STI always stalls even
    // when it completes, because the second access still has to follow.
    always_comb begin
        dstall = dmem_req & (~dmem_resp | ((state_q == M_IDLE) & mem_indirect));
        istall = imem_req & ~imem_resp;
        luse   = ex_is_load & ((id_use1 & (id_src1 == ex_dest)) |
                               (id_use2 & (id_src2 == ex_dest)));
    end

    // MEM-stage indirect-access FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            M_IDLE: if (dmem_req & mem_indirect & dmem_resp) state_d = M_IND2;
            M_IND2: if (dmem_resp) state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    // Prioritised latch control; a stalled data access dominates everything.
    always_comb begin
        load_pc            = 1'b1;
        load_if_id         = 1'b1;
        load_id_ex         = 1'b1;
        load_ex_mem        = 1'b1;
        load_mem_wb        = 1'b1;
        bubble_if_id       = 1'b0;
        bubble_id_ex       = 1'b0;
        bubble_ex_mem      = 1'b0;
        bubble_mem_wb      = 1'b0;
        pc_redirect        = 1'b0;
        redirect_target    = redirect_target_q;
        redirect_pending_d = redirect_pending_q;
        redirect_target_d  = redirect_target_q;
        if (reset) begin
            bubble_if_id  = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (dstall) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            load_ex_mem   = 1'b0;
            bubble_mem_wb = 1'b1;
        end else if (br_taken_mem & istall) begin
            // Squash the wrong path now; redirect once the fetch returns.
            load_pc            = 1'b0;
            load_if_id         = 1'b0;
            bubble_id_ex       = 1'b1;
            bubble_ex_mem      = 1'b1;
            redirect_pending_d = 1'b1;
            redirect_target_d  = br_target;
        end else if (br_taken_mem) begin
            bubble_if_id       = 1'b1;
            bubble_id_ex       = 1'b1;
            bubble_ex_mem      = 1'b1;
            pc_redirect        = 1'b1;
            redirect_target    = br_target;
            redirect_pending_d = 1'b0;
        end else if (istall) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            bubble_id_ex = 1'b1;
        end else if (redirect_pending_q & imem_resp) begin
            bubble_if_id       = 1'b1;
            pc_redirect        = 1'b1;
            redirect_pending_d = 1'b0;
        end else if (luse) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            bubble_id_ex = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!load_pc && (stall_cycles_q != {CNT_WIDTH{1'b1}}))
            stall_cycles_d = stall_cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= M_IDLE;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= 16'h0000;
            stall_cycles_q     <= '0;
        end else begin
            state_q            <= state_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_target_q  <= redirect_target_d;
            stall_cycles_q     <= stall_cycles_d;
        end
    end

    assign mem_phase2   = (state_q == M_IND2);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios, random traffic and a long
// counter-saturation run, checked through an expected-response queue.
module tb_pipeline_hazard_ctrl;
  localparam int W = 43;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect;
  logic        br_taken_mem, ex_is_load, id_use1, id_use2;
  logic [15:0] br_target;
  logic [2:0]  ex_dest, id_src1, id_src2;
  logic        load_pc, pc_redirect, mem_phase2;
  logic [15:0] redirect_target, stall_cycles;
  logic        load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb;

  pipeline_hazard_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .mem_indirect(mem_indirect),
    .br_taken_mem(br_taken_mem), .br_target(br_target), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .load_pc(load_pc), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
    .mem_phase2(mem_phase2), .stall_cycles(stall_cycles)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: what each latch does this cycle, plus architectural state
  typedef enum int {HOLD, PASS, NOP} act_e;
  logic        m_ind2, m_pend;
  logic [15:0] m_tgt;
  int          m_cnt;

  function automatic logic [W-1:0] pack(input logic pc, input logic rd, input logic [15:0] rt,
                                        input act_e a[4], input logic ph2, input int cnt);
    logic [3:0] ld, bb;
    for (int k = 0; k < 4; k++) begin
      ld[3-k] = (a[k] != HOLD);
      bb[3-k] = (a[k] == NOP);
    end
    return {pc, rd, rt, ld, bb, ph2, cnt[15:0]};
  endfunction

  // driver: evaluate model on current inputs, push expectation, advance one clock
  task automatic tick();
    act_e        a[4];
    logic        pc_go, rd, hazard, mem_wait, fetch_wait, n_pend;
    logic [15:0] rt, n_tgt;
    logic [2:0]  srcs[2];
    logic        uses[2];
    srcs = '{id_src1, id_src2};
    uses = '{id_use1, id_use2};
    hazard = 1'b0;
    for (int k = 0; k < 2; k++)
      if (ex_is_load && uses[k] && srcs[k] == ex_dest) hazard = 1'b1;
    mem_wait   = dmem_req && (!dmem_resp || (!m_ind2 && mem_indirect));
    fetch_wait = imem_req && !imem_resp;
    a = '{PASS, PASS, PASS, PASS};
    pc_go = 1'b1; rd = 1'b0; rt = m_tgt; n_pend = m_pend; n_tgt = m_tgt;
    if (reset) a = '{NOP, NOP, NOP, NOP};
    else if (mem_wait) begin a = '{HOLD, HOLD, HOLD, NOP}; pc_go = 1'b0; end
    else if (br_taken_mem && fetch_wait) begin
      a = '{HOLD, NOP, NOP, PASS}; pc_go = 1'b0; n_pend = 1'b1; n_tgt = br_target;
    end
    else if (br_taken_mem) begin
      a = '{NOP, NOP, NOP, PASS}; rd = 1'b1; rt = br_target; n_pend = 1'b0;
    end
    else if (fetch_wait) begin a = '{HOLD, NOP, PASS, PASS}; pc_go = 1'b0; end
    else if (m_pend && imem_resp) begin a = '{NOP, PASS, PASS, PASS}; rd = 1'b1; n_pend = 1'b0; end
    else if (hazard) begin a = '{HOLD, NOP, PASS, PASS}; pc_go = 1'b0; end
    exp_q.push_back(pack(pc_go, rd, rt, a, m_ind2, m_cnt));
    @(posedge clk);
    if (reset) begin
      m_ind2 = 1'b0; m_pend = 1'b0; m_tgt = 16'h0; m_cnt = 0;
    end else begin
      if (!m_ind2 && dmem_req && mem_indirect && dmem_resp) m_ind2 = 1'b1;
      else if (m_ind2 && dmem_resp) m_ind2 = 1'b0;
      if (!pc_go && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_pend = n_pend; m_tgt = n_tgt;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    mem_indirect = 0; br_taken_mem = 0; br_target = 16'h0; ex_is_load = 0;
    ex_dest = 0; id_src1 = 0; id_src2 = 0; id_use1 = 0; id_use2 = 0;
  endtask

  // monitor: combinational outputs sampled mid-cycle against the oldest expectation
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {load_pc, pc_redirect, redirect_target, load_if_id, load_id_ex, load_ex_mem,
             load_mem_wb, bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
             mem_phase2, stall_cycles};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL ctl_vec cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      cyc++;
    end
  end

  initial begin
    int wait_cnt;
    m_ind2 = 0; m_pend = 0; m_tgt = 0; m_cnt = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    // reset cycle then idle
    tick();
    reset = 0; tick(); tick();
    // data-memory wait: three stalled cycles then completion
    dmem_req = 1;
    repeat (3) tick();
    dmem_resp = 1; tick();
    idle(); tick();
    // LDI: first access completes in cycle 2, second in cycle 5
    dmem_req = 1; mem_indirect = 1;
    tick();
    dmem_resp = 1; tick();
    dmem_resp = 0; tick(); tick();
    dmem_resp = 1; tick();
    idle(); tick();
    // load-use on src2, then same without the read
    ex_is_load = 1; ex_dest = 3; id_use2 = 1; id_src2 = 3; tick();
    idle(); tick();
    ex_is_load = 1; ex_dest = 3; id_use2 = 0; id_src2 = 3; tick();
    idle(); tick();
    // taken branch while fetch outstanding, fetch returns two cycles later
    br_taken_mem = 1; br_target = 16'h3000; imem_req = 1; tick();
    br_taken_mem = 0; br_target = 16'h0; tick();
    imem_resp = 1; tick();
    idle(); tick();
    // branch with fetch complete, and a newer branch overriding a pending one
    br_taken_mem = 1; br_target = 16'h1234; tick();
    br_taken_mem = 1; br_target = 16'h2000; imem_req = 1; tick();
    br_target = 16'h4444; tick();
    br_taken_mem = 0; imem_resp = 1; tick();
    idle(); tick();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      imem_req     = ($urandom_range(0, 3) != 0);
      imem_resp    = $urandom_range(0, 1);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_resp    = $urandom_range(0, 1);
      mem_indirect = ($urandom_range(0, 2) == 0);
      br_taken_mem = ($urandom_range(0, 7) == 0);
      br_target    = 16'($urandom);
      ex_is_load   = $urandom_range(0, 1);
      ex_dest      = 3'($urandom_range(0, 7));
      id_src1      = 3'($urandom_range(0, 7));
      id_src2      = 3'($urandom_range(0, 7));
      id_use1      = $urandom_range(0, 1);
      id_use2      = $urandom_range(0, 1);
      tick();
    end
    // counter saturation: 0xFFFF stalled cycles plus two more
    idle(); reset = 1; tick();
    reset = 0; imem_req = 1;
    repeat (65537) tick();
    idle(); tick(); tick();
    // drain scoreboard with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
